// File: rtl/load_store_unit.sv
// Load/store initiator for the byte-addressed data ram: checks size/alignment/range, drives the ram port, extends load data.
// Three cycles per access (IDLE accept, ACCESS, RESP); response is held until resp_ready, and no new request is taken meanwhile.
module load_store_unit #(
    parameter int MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [2:0]  mem_write_enable,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]  state;
    logic        lat_store;
    logic [2:0]  lat_funct3;
    logic        lat_err;
    logic        req_err;
    logic [2:0]  size;
    logic [32:0] end_addr;
    logic [31:0] load_data;

    // Error check on the incoming request; the 33-bit end address cannot wrap.
    always_comb begin
        size = 3'd1;
        case (req_funct3)
            3'b001, 3'b101: size = 3'd2;
            3'b010:         size = 3'd4;
            default:        size = 3'd1;
        endcase
        end_addr = {1'b0, req_addr} + {30'b0, size};
        req_err = 1'b0;
        case (req_funct3)
            3'b000: req_err = 1'b0;
            3'b001: req_err = req_addr[0];
            3'b010: req_err = (req_addr[1:0] != 2'b00);
            3'b100: req_err = req_store;
            3'b101: req_err = req_store | req_addr[0];
            default: req_err = 1'b1;
        endcase
        if (end_addr > 33'(MEM_BYTES))
            req_err = 1'b1;
    end

    // Ram data is big-endian, so the addressed byte/half sits in the top bits.
    always_comb begin
        load_data = 32'd0;
        case (lat_funct3)
            3'b010: load_data = mem_rdata;
            3'b001: load_data = {{16{mem_rdata[31]}}, mem_rdata[31:16]};
            3'b101: load_data = {16'd0, mem_rdata[31:16]};
            3'b000: load_data = {{24{mem_rdata[31]}}, mem_rdata[31:24]};
            3'b100: load_data = {24'd0, mem_rdata[31:24]};
            default: load_data = 32'd0;
        endcase
    end

    always_comb begin
        mem_write_enable = 3'b000;
        if (state == ACCESS && lat_store && !lat_err && !reset) begin
            case (lat_funct3)
                3'b010:  mem_write_enable = 3'b001;
                3'b001:  mem_write_enable = 3'b010;
                3'b000:  mem_write_enable = 3'b100;
                default: mem_write_enable = 3'b000;
            endcase
        end
    end

    assign req_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            lat_store  <= 1'b0;
            lat_funct3 <= 3'b000;
            lat_err    <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_store  <= req_store;
                        lat_funct3 <= req_funct3;
                        lat_err    <= req_err;
                        mem_addr   <= req_addr;
                        mem_wdata  <= req_wdata;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    resp_error <= lat_err;
                    resp_rdata <= (lat_store || lat_err) ? 32'd0 : load_data;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural big-endian ram attached to the mem port.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [2:0]  mem_write_enable;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int failures = 0;
    int pops = 0;
    int we_seen = 0;
    logic [2:0] we_last = 3'b000;
    logic [32:0] exp_q[$];
    logic [7:0] ram [0:4095];

    load_store_unit #(.MEM_BYTES(4096)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .mem_write_enable(mem_write_enable),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rb(input logic [31:0] a);
        return (a < 32'd4096) ? ram[a[11:0]] : 8'h00;
    endfunction

    assign mem_rdata = {rb(mem_addr), rb(mem_addr + 32'd1), rb(mem_addr + 32'd2), rb(mem_addr + 32'd3)};

    always @(posedge clk) begin
        if (mem_addr < 32'd4093) begin
            case (mem_write_enable)
                3'b001: begin
                    ram[mem_addr[11:0]]         <= mem_wdata[31:24];
                    ram[mem_addr[11:0] + 12'd1] <= mem_wdata[23:16];
                    ram[mem_addr[11:0] + 12'd2] <= mem_wdata[15:8];
                    ram[mem_addr[11:0] + 12'd3] <= mem_wdata[7:0];
                end
                3'b010: begin
                    ram[mem_addr[11:0]]         <= mem_wdata[15:8];
                    ram[mem_addr[11:0] + 12'd1] <= mem_wdata[7:0];
                end
                3'b100: ram[mem_addr[11:0]] <= mem_wdata[7:0];
                default: ;
            endcase
        end else if (mem_addr < 32'd4096 && mem_write_enable == 3'b001) begin
            ram[mem_addr[11:0]]         <= mem_wdata[31:24];
            ram[mem_addr[11:0] + 12'd1] <= mem_wdata[23:16];
            ram[mem_addr[11:0] + 12'd2] <= mem_wdata[15:8];
            ram[mem_addr[11:0] + 12'd3] <= mem_wdata[7:0];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pop an expectation on every accepted response and track write strobes.
    always @(negedge clk) begin
        if (mem_write_enable != 3'b000) begin
            we_seen++;
            we_last = mem_write_enable;
        end
        if (resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", {31'd0, resp_error, resp_rdata}, 64'h1_FFFF_FFFF);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("resp_data_err", {31'd0, resp_error, resp_rdata}, {31'd0, e});
            end
            pops++;
        end
    end

    task automatic do_req(input string name, input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                          input logic [2:0] exp_we);
        int lat;
        int p0;
        @(negedge clk);
        req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        we_seen = 0; we_last = 3'b000;
        p0 = pops;
        @(posedge clk);
        #1 req_valid = 1'b0;
        exp_q.push_back({exp_err, exp_rd});
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (resp_valid) break;
        end
        check({name, "_latency"}, 64'(lat), 64'd2);
        lat = 0;
        while (pops == p0 && lat < 20) begin
            @(posedge clk);
            lat++;
        end
        if (pops == p0) check({name, "_timeout"}, 64'(pops), 64'(p0 + 1));
        check({name, "_we"}, {32'(we_seen), 29'd0, we_last}, (exp_we != 3'b000) ? {32'd1, 29'd0, exp_we} : 64'd0);
    endtask

    task automatic check_outputs_reset(input string name);
        check({name, "_outs"}, {resp_valid, resp_error, req_ready, mem_write_enable, resp_rdata},
              {1'b0, 1'b0, 1'b1, 3'b000, 32'd0});
        check({name, "_mem"}, {mem_addr, mem_wdata}, 64'd0);
    endtask

    initial begin
        logic [31:0] held;
        int n;
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_outputs_reset("reset");

        do_req("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 3'b001);
        check("ram10", {ram[16], ram[17], ram[18], ram[19]}, 64'hDEADBEEF);
        do_req("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3'b000);
        do_req("sb20", 1'b1, 3'b000, 32'h20, 32'h00000080, 32'h0, 1'b0, 3'b100);
        do_req("lb20", 1'b0, 3'b000, 32'h20, 32'h0, 32'hFFFFFF80, 1'b0, 3'b000);
        do_req("lbu20", 1'b0, 3'b100, 32'h20, 32'h0, 32'h00000080, 1'b0, 3'b000);
        do_req("sh22", 1'b1, 3'b001, 32'h22, 32'h0000F00D, 32'h0, 1'b0, 3'b010);
        check("ram22", {ram[34], ram[35]}, 64'hF00D);
        do_req("lh22", 1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFFF00D, 1'b0, 3'b000);
        do_req("lhu22", 1'b0, 3'b101, 32'h22, 32'h0, 32'h0000F00D, 1'b0, 3'b000);
        do_req("lw11", 1'b0, 3'b010, 32'h11, 32'h0, 32'h0, 1'b1, 3'b000);
        do_req("sh23", 1'b1, 3'b001, 32'h23, 32'h1234, 32'h0, 1'b1, 3'b000);
        do_req("swffc", 1'b1, 3'b010, 32'hFFC, 32'h01020304, 32'h0, 1'b0, 3'b001);
        check("ramffc", {ram[4092], ram[4093], ram[4094], ram[4095]}, 64'h01020304);
        do_req("swffe", 1'b1, 3'b010, 32'hFFE, 32'h55555555, 32'h0, 1'b1, 3'b000);
        do_req("st_f3_100", 1'b1, 3'b100, 32'h30, 32'hAA, 32'h0, 1'b1, 3'b000);
        do_req("ld_f3_011", 1'b0, 3'b011, 32'h30, 32'h0, 32'h0, 1'b1, 3'b000);
        do_req("lbufff", 1'b0, 3'b100, 32'hFFF, 32'h0, 32'h00000004, 1'b0, 3'b000);
        do_req("lb1000", 1'b0, 3'b000, 32'h1000, 32'h0, 32'h0, 1'b1, 3'b000);
        do_req("lwwrap", 1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1, 3'b000);

        // Backpressure: response stalls, and a request held high meanwhile must not be taken.
        @(negedge clk);
        resp_ready = 1'b0;
        req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0; req_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        #1 req_store = 1'b1; req_addr = 32'h80; req_wdata = 32'h12345678;
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", {63'd0, resp_valid}, 64'd1);
        held = resp_rdata;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", {resp_valid, req_ready, resp_error, held, resp_rdata},
                  {1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF});
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("bp_req_ready", {63'd0, req_ready}, 64'd1);
        check("bp_no_accept", {ram[128], ram[129], ram[130], ram[131]}, 64'd0);

        // Reset lands while the store is in ACCESS.
        @(negedge clk);
        req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0; reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_outputs_reset("midreset");
        @(posedge clk);
        check("ram40", {ram[64], ram[65], ram[66], ram[67]}, 64'd0);
        do_req("sw40", 1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0, 3'b001);
        do_req("lw40", 1'b0, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 3'b000);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
